// File: rtl/p4_dispatcher.sv
// Head-of-pipeline splitter: spreads packet heads over 4 lanes and records lane order for P4Arbiter.
// Optional build macro P4_DISPATCH_STEER_EN steers on next_idx[1:0] instead of round-robin.
module p4_dispatcher #(
  parameter int IDX_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [15:0] io_in_bits_head_eth_type,
  input  logic [31:0] io_in_bits_head_next_idx,
  input  logic [31:0] io_in_bits_head_bitmap,
  input  logic [31:0] io_in_bits_head_index,
  input  logic        io_in_bits_is_empty,
  output logic        io_out_0_valid,
  input  logic        io_out_0_ready,
  output logic [15:0] io_out_0_bits_head_eth_type,
  output logic [31:0] io_out_0_bits_head_next_idx,
  output logic [31:0] io_out_0_bits_head_bitmap,
  output logic [31:0] io_out_0_bits_head_index,
  output logic        io_out_0_bits_is_empty,
  output logic        io_out_1_valid,
  input  logic        io_out_1_ready,
  output logic [15:0] io_out_1_bits_head_eth_type,
  output logic [31:0] io_out_1_bits_head_next_idx,
  output logic [31:0] io_out_1_bits_head_bitmap,
  output logic [31:0] io_out_1_bits_head_index,
  output logic        io_out_1_bits_is_empty,
  output logic        io_out_2_valid,
  input  logic        io_out_2_ready,
  output logic [15:0] io_out_2_bits_head_eth_type,
  output logic [31:0] io_out_2_bits_head_next_idx,
  output logic [31:0] io_out_2_bits_head_bitmap,
  output logic [31:0] io_out_2_bits_head_index,
  output logic        io_out_2_bits_is_empty,
  output logic        io_out_3_valid,
  input  logic        io_out_3_ready,
  output logic [15:0] io_out_3_bits_head_eth_type,
  output logic [31:0] io_out_3_bits_head_next_idx,
  output logic [31:0] io_out_3_bits_head_bitmap,
  output logic [31:0] io_out_3_bits_head_index,
  output logic        io_out_3_bits_is_empty,
  output logic        io_idx_valid,
  input  logic        io_idx_ready,
  output logic [1:0]  io_idx_bits
);

  localparam int PW = $clog2(IDX_DEPTH);
  localparam int CW = PW + 1;

  // Packed head layout: {eth_type, next_idx, bitmap, index, is_empty}
  typedef logic [112:0] head_t;

  logic [3:0]    out_ready, lane_free, lane_load;
  logic [3:0]    lane_v_q, lane_v_d;
  head_t         lane_data_q [4];
  head_t         lane_data_d [4];
  head_t         in_head;
  logic [1:0]    sel;
  logic          in_fire, idx_full, idx_push, idx_pop;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_mem_q [IDX_DEPTH];
  logic [1:0]    idx_mem_d [IDX_DEPTH];

  assign out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
  assign in_head   = {io_in_bits_head_eth_type, io_in_bits_head_next_idx,
                      io_in_bits_head_bitmap, io_in_bits_head_index, io_in_bits_is_empty};

`ifdef P4_DISPATCH_STEER_EN
  assign sel = io_in_bits_head_next_idx[1:0];
`else
  logic [1:0] rr_q, rr_d;
  assign sel = rr_q;
  always_comb rr_d = in_fire ? rr_q + 2'd1 : rr_q;
  always_ff @(posedge clock) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  // Every port transfers on valid && ready; a raised valid holds with stable bits until ready.
  // A blocked selected lane stalls the input; no other lane is tried.
  assign lane_free   = ~lane_v_q | out_ready;
  assign idx_full    = (count_q == CW'(IDX_DEPTH));
  assign io_in_ready = !reset && lane_free[sel] && !idx_full;
  assign in_fire     = io_in_valid && io_in_ready;
  assign idx_push    = in_fire;
  assign io_idx_valid = (count_q != '0);
  assign idx_pop     = io_idx_valid && io_idx_ready;
  assign io_idx_bits = idx_mem_q[rd_ptr_q];

  always_comb begin
    lane_load = '0;
    if (in_fire) lane_load[sel] = 1'b1;
    lane_v_d = (lane_v_q & ~out_ready) | lane_load;
    for (int n = 0; n < 4; n++) begin
      lane_data_d[n] = lane_load[n] ? in_head : lane_data_q[n];
    end
  end

  always_comb begin
    idx_mem_d = idx_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (idx_push) begin
      idx_mem_d[wr_ptr_q] = sel;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (idx_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({idx_push, idx_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_v_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      lane_v_q <= lane_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; the valid bits and count gate it.
  always_ff @(posedge clock) begin
    lane_data_q <= lane_data_d;
    idx_mem_q   <= idx_mem_d;
  end

  assign io_out_0_valid = lane_v_q[0];
  assign io_out_1_valid = lane_v_q[1];
  assign io_out_2_valid = lane_v_q[2];
  assign io_out_3_valid = lane_v_q[3];

  assign {io_out_0_bits_head_eth_type, io_out_0_bits_head_next_idx, io_out_0_bits_head_bitmap,
          io_out_0_bits_head_index, io_out_0_bits_is_empty} = lane_data_q[0];
  assign {io_out_1_bits_head_eth_type, io_out_1_bits_head_next_idx, io_out_1_bits_head_bitmap,
          io_out_1_bits_head_index, io_out_1_bits_is_empty} = lane_data_q[1];
  assign {io_out_2_bits_head_eth_type, io_out_2_bits_head_next_idx, io_out_2_bits_head_bitmap,
          io_out_2_bits_head_index, io_out_2_bits_is_empty} = lane_data_q[2];
  assign {io_out_3_bits_head_eth_type, io_out_3_bits_head_next_idx, io_out_3_bits_head_bitmap,
          io_out_3_bits_head_index, io_out_3_bits_is_empty} = lane_data_q[3];

endmodule
